// File: rtl/sdram_arb_pkg.sv
// Shared SDRAM widths, arbiter defaults and arbiter FSM state encodings.
// Types and constants only; no logic, no latency, no flow control.
package sdram_arb_pkg;

  localparam int SDRAM_ADDR_W   = 24;
  localparam int SDRAM_DATA_W   = 32;
  localparam int ARB_MAX_OUTST  = 4;
  localparam int ARB_STARVE_LIM = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_CMD   = 2'd1,
    WR_DRAIN = 2'd2,
    WR_CMD   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sdram_arb_outst.sv
// Outstanding-read counter: +1 per read accept, -1 per returned word, clamped to 0..MAX_OUTST.
// Count updates 1 cycle after inc/dec; full blocks new read grants upstream.
module sdram_arb_outst
  import sdram_arb_pkg::*;
#(
  parameter int MAX_OUTST = ARB_MAX_OUTST
) (
  input  logic                             mclk,
  input  logic                             rst,
  input  logic                             inc,
  input  logic                             dec,
  output logic [$clog2(MAX_OUTST+1)-1:0]   cnt,
  output logic                             full,
  output logic                             empty
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic inc_ok;
  logic dec_ok;

  assign full   = (cnt == CNT_W'(MAX_OUTST));
  assign empty  = (cnt == '0);
  assign inc_ok = inc & ~full;
  // A return with nothing outstanding is stale (e.g. from before a reset) and is dropped.
  assign dec_ok = dec & ~empty;

  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// Read-priority arbiter sharing one SDRAM command port between the loader (writes) and DAC reader.
// Command launches 1 cycle after grant and holds through mem_waitrequest; read data returns 1 cycle after mem_rdv.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W     = SDRAM_ADDR_W,
  parameter int DATA_W     = SDRAM_DATA_W,
  parameter int MAX_OUTST  = ARB_MAX_OUTST,
  parameter int STARVE_LIM = ARB_STARVE_LIM
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_dv,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_waitrequest,
  input  logic              mem_rdv,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int SC_W  = $clog2(STARVE_LIM + 1);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [SC_W-1:0]  starve_cnt;
  logic [CNT_W-1:0] outst_cnt;
  logic             outst_full;
  logic             outst_empty;
  logic             rd_accept;
  logic             wr_accept;
  logic             grant_rd;
  logic             grant_wr;
  logic             starved;
  logic             drain_done;

  assign rd_accept = mem_rd & ~mem_waitrequest;
  assign wr_accept = mem_wr & ~mem_waitrequest;
  assign rd_ack    = rd_accept;
  assign wr_ack    = wr_accept;
  assign starved   = (starve_cnt == SC_W'(STARVE_LIM));
  // Leave drain on the cycle the last read returns so the write launches right after it.
  assign drain_done = outst_empty | ((outst_cnt == CNT_W'(1)) & mem_rdv);
  assign busy       = (state != IDLE) | ~outst_empty;

  sdram_arb_outst #(
    .MAX_OUTST(MAX_OUTST)
  ) u_outst (
    .mclk  (mclk),
    .rst   (rst),
    .inc   (rd_accept),
    .dec   (mem_rdv),
    .cnt   (outst_cnt),
    .full  (outst_full),
    .empty (outst_empty)
  );

  always_comb begin
    state_nxt = state;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req && (!rd_req || starved)) begin
          grant_wr  = 1'b1;
          state_nxt = outst_empty ? WR_CMD : WR_DRAIN;
        end else if (rd_req && !outst_full) begin
          grant_rd  = 1'b1;
          state_nxt = RD_CMD;
        end
      end
      RD_CMD:   if (rd_accept)  state_nxt = IDLE;
      WR_DRAIN: if (drain_done) state_nxt = WR_CMD;
      WR_CMD:   if (wr_accept)  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_dv      <= 1'b0;
      rd_data    <= '0;
    end else begin
      state <= state_nxt;
      rd_dv <= mem_rdv & ~outst_empty;
      if (mem_rdv && !outst_empty) rd_data <= mem_rdata;

      if (grant_rd) begin
        mem_rd   <= 1'b1;
        mem_addr <= rd_addr;
      end else if (rd_accept) begin
        mem_rd <= 1'b0;
      end

      // Write address/data are captured at grant even when the write must first drain.
      if (grant_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end

      if (state != WR_CMD && state_nxt == WR_CMD) mem_wr <= 1'b1;
      else if (wr_accept)                         mem_wr <= 1'b0;

      if (!wr_req || wr_accept)       starve_cnt <= '0;
      else if (rd_accept && !starved) starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

endmodule

// File: doc/sdram_arb.md
Name: sdram_arb

Overview:
- Two-port arbiter that shares the single SDRAM controller port between the flash-to-SDRAM loader (write requester) and the DAC playback reader (read requester).
- Reads carry real-time DAC samples, so they get priority.
- A starvation counter guarantees that writes still make forward progress.
- Placed between the flow-control logic and the SDRAM controller; it tracks outstanding reads and routes read data back to the read requester.

Parameters:
ADDR_W, 24, SDRAM word address width
DATA_W, 32, SDRAM data width
MAX_OUTST, 4, maximum reads issued but not yet returned (power of 2, 2..16)
STARVE_LIM, 8, consecutive read grants allowed while a write is pending before one write is forced

Ports:
mclk  in  1  main clock
rst  in  1  synchronous active-high reset
wr_req  in  1  write requester has a word pending
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ack  out  1  1-cycle pulse: write accepted by SDRAM
rd_req  in  1  read requester has an address pending
rd_addr  in  ADDR_W  read address
rd_ack  out  1  1-cycle pulse: read accepted by SDRAM
rd_dv  out  1  returned read data valid
rd_data  out  DATA_W  returned read data
mem_wr  out  1  SDRAM write command
mem_rd  out  1  SDRAM read command
mem_addr  out  ADDR_W  SDRAM address
mem_wdata  out  DATA_W  SDRAM write data
mem_waitrequest  in  1  SDRAM stall; a command is held while high
mem_rdv  in  1  SDRAM read data valid
mem_rdata  in  DATA_W  SDRAM read data
busy  out  1  command in flight or reads outstanding

Behaviour:
- Reset (synchronous, active-high, on the mclk edge) forces every output and register to 0 and the FSM to IDLE. A reset during operation abandons in-flight reads; any mem_rdv arriving after reset is ignored, because the outstanding count is 0.
- FSM states:
  - IDLE: arbitrate.
  - RD_CMD: hold mem_rd until accepted.
  - WR_DRAIN: wait for the outstanding read count to reach 0.
  - WR_CMD: hold mem_wr until accepted.
- Arbitration in IDLE, evaluated on registered state:
  - A write is chosen if wr_req is high and either (rd_req is low) or (starve_cnt == STARVE_LIM).
  - Otherwise a read is chosen if rd_req is high and outst < MAX_OUTST.
  - If rd_req is high with outst == MAX_OUTST and wr_req is low, stay in IDLE.
- Going to a write: the next state is WR_DRAIN if outst != 0, else WR_CMD. No write is issued while reads are outstanding (turnaround rule).
- Command phase:
  - mem_addr, mem_wdata, mem_rd and mem_wr are registered and launched the cycle after the grant.
  - They are held stable while mem_waitrequest is high.
  - The command is accepted on a cycle where the command is high and mem_waitrequest is low.
  - On that cycle rd_ack or wr_ack pulses for 1 cycle, the command deasserts next cycle, and the FSM returns to IDLE.
  - Minimum issue rate: 1 command per 2 cycles.
- Requester rules:
  - rd_addr, wr_addr and wr_data are sampled at grant.
  - Requesters keep their req high and their data stable until ack, and may drop req only after ack.
- starve_cnt (0..STARVE_LIM, saturating):
  - Increments on each read accept while wr_req is high.
  - Clears on write accept, or whenever wr_req is low.
- outst counter:
  - +1 on read accept, -1 on mem_rdv. Both on the same cycle means no change.
  - Never exceeds MAX_OUTST.
  - A mem_rdv when outst == 0 is ignored and does not underflow.
- Read return: rd_dv and rd_data are mem_rdv and mem_rdata registered, so rd_dv follows mem_rdv with 1 cycle latency. Return order equals issue order; there is no reordering.
- busy = (FSM != IDLE) | (outst != 0).
- Simultaneous rd_req and wr_req with starve_cnt < STARVE_LIM: the read wins.

Decomposition:
- Shared package/globals: the state encodings (IDLE/RD_CMD/WR_DRAIN/WR_CMD) and the defaults for ADDR_W, DATA_W, MAX_OUTST and STARVE_LIM, alongside the existing SDRAM width defines.
- One natural sub-module: sdram_arb_outst, the outstanding-read up/down counter with saturate/underflow guard, which provides full and empty flags.

Test Plan:
- Read only: rd_req held high, rd_addr=0x10, waitrequest=0, mem_rdv 3 cycles after each mem_rd -> mem_rd at cycle 1, rd_ack at cycle 1, rd_dv 1 cycle after each mem_rdv with matching data. After 4 unreturned reads, no 5th mem_rd until a mem_rdv arrives.
- Write only: wr_req, wr_addr=0x2A, wr_data=0xDEADBEEF, waitrequest high for 3 cycles -> mem_wr/mem_addr/mem_wdata stable for 4 cycles, then one wr_ack pulse.
- Starvation: rd_req and wr_req both held high continuously -> exactly 8 read accepts, then 1 write (after outstanding reads drain to 0), then reads resume; pattern repeats.
- Drain: 3 reads outstanding, wr_req rises, rd_req falls -> FSM in WR_DRAIN, mem_wr stays low until the 3rd mem_rdv, then mem_wr the next cycle.
- Simultaneous: read accept and mem_rdv on the same cycle with outst=2 -> outst stays 2. A spurious mem_rdv with outst=0 -> no rd_dv change to the count and no underflow (outst stays 0).
- Reset mid-write with waitrequest high -> next cycle all outputs are 0, FSM is IDLE and outst=0.
